// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver with mid-bit sampling; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Clocks per bit and the bit-period counter geometry.
  localparam int T  = CLK_FREQ / BAUD_RATE;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] C_HALF = CW'(T / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(T - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // Synchronizer flops; both idle high like the line itself.
  logic          r_rx_meta;
  logic          r_rx_s;

  state_t        r_state;
  state_t        w_next_state;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;

  logic [7:0]    r_data_out;
  logic          r_data_valid;
  logic          r_frame_err;
  logic          r_busy;

  logic          w_cnt_hit;
  logic          w_mismatch;
  logic          w_load;
  logic          w_ferr;

`ifdef UART_RX_PARITY_EN
  logic          r_mismatch;
  logic          r_parity_err;
  logic          w_perr;
`endif

  // Two-flop synchronizer bringing the asynchronous line into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The start bit is checked at its midpoint; every later bit one full period on.
  assign w_cnt_hit = (r_state == S_START) ? (r_cnt == C_HALF) : (r_cnt == C_FULL);

`ifdef UART_RX_PARITY_EN
  assign w_mismatch = r_mismatch;
`else
  assign w_mismatch = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        // A line that is high again at mid-start was only a glitch.
        if (w_cnt_hit) begin
          w_next_state = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_hit && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_hit) begin
          w_next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // A low stop bit may be a line break, so wait for the line to return high.
        if (w_cnt_hit) begin
          w_next_state = r_rx_s ? S_IDLE : S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_rx_s) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM output decode: frame verdict at the stop-bit sample point.
  always_comb begin
    w_load = 1'b0;
    w_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr = 1'b0;
`endif
    if ((r_state == S_STOP) && w_cnt_hit) begin
      w_load = r_rx_s && !w_mismatch;
      w_ferr = !r_rx_s;
`ifdef UART_RX_PARITY_EN
      w_perr = w_mismatch;
`endif
    end
  end

  // Bit-period counter; wraps to zero at every sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_RECOVER) || w_cnt_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  // Data bit index; wraps back to zero after the eighth bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= 3'd0;
    end else if (r_state == S_IDLE) begin
      r_idx <= 3'd0;
    end else if ((r_state == S_DATA) && w_cnt_hit) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // Assemble the byte LSB first at each data sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 8'h00;
    end else if ((r_state == S_DATA) && w_cnt_hit) begin
      r_shift[r_idx] <= r_rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even-parity check: data plus parity bit must XOR to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mismatch <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == S_PARITY) && w_cnt_hit) begin
      r_mismatch <= ^{r_shift, r_rx_s};
    end
  end

  // Parity error strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Registered outputs: result strobes, held byte and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= w_load;
      r_frame_err  <= w_ferr;
      r_busy       <= (w_next_state != S_IDLE);
      if (w_load) begin
        r_data_out <= r_shift;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at T=16
module tb_uart_rx;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD_RATE = 1;
  localparam int T         = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int LAT_LO = 170;
  localparam int LAT_HI = 172;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int LAT_LO = 154;
  localparam int LAT_HI = 156;
`endif

  // flags are {parity_err, frame_err, data_valid}
  localparam logic [2:0] F_VALID = 3'b001;
  localparam logic [2:0] F_FERR  = 3'b010;
  localparam logic [2:0] F_PERR  = 3'b100;

  typedef struct {
    logic [2:0] flags;
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t got;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(T);
  endtask

  // Drives one frame and pushes the result the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok,
                            input logic [2:0] flags);
    exp_t e;
    e.flags = flags;
    e.data  = d;
    e.start = cyc;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ !par_ok);
    drive_bit(stop_b);
  endtask

  // Every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (data_valid || frame_err || parity_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, parity_err, frame_err, data_valid}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("pulse_flags", {29'd0, parity_err, frame_err, data_valid}, {29'd0, got.flags});
        if (got.flags[0]) check("data_out", data_out, got.data);
        check("latency_in_window",
              ((cyc - got.start) >= LAT_LO && (cyc - got.start) <= LAT_HI) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    tick(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick(5);

    // single good byte
    send_frame(8'hA5, 1'b1, 1'b1, F_VALID);
    tick(T);
    check("idle_busy_a5", busy, 0);

    // back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b1, F_VALID);
    send_frame(8'hFF, 1'b1, 1'b1, F_VALID);
    tick(T);

    // short low glitch
    rx = 1'b0;
    tick(4);
    check("glitch_busy_set", busy, 1);
    rx = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      tick(1);
      n++;
    end
    check("glitch_busy_clear", busy, 0);
    tick(2 * T);
    check("glitch_data_hold", data_out, 8'hFF);

    // framing error followed by a line break, then recovery
    send_frame(8'h11, 1'b1, 1'b1, F_VALID);
    tick(T);
    send_frame(8'h3C, 1'b0, 1'b1, F_FERR);
    tick(40);
    check("break_data_hold", data_out, 8'h11);
    check("break_busy", busy, 1);
    rx = 1'b1;
    tick(2 * T);
    check("recover_idle", busy, 0);
    send_frame(8'h5A, 1'b1, 1'b1, F_VALID);
    tick(T);

    // reset during data bit 3 of 0x81
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    tick(T / 2);
    rst = 1'b0;
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_ferr", frame_err, 0);
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2 * T);
    send_frame(8'h81, 1'b1, 1'b1, F_VALID);
    tick(T);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, F_VALID);
    tick(T);
    send_frame(8'h07, 1'b1, 1'b0, F_PERR);
    tick(T);
    check("perr_data_hold", data_out, 8'h07);
`endif

    tick(3 * T);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8-bit UART link, the far end of the board's UART transmitter. It recovers bytes from the asynchronous `rx` line using mid-bit sampling at a clock-derived bit period. Each good byte is presented on `data_out` with a single-cycle `data_valid` strobe, and framing errors are flagged. It sits on the host/bridge side of the link, so temperature bytes streamed by the sensor board can be looped back or consumed on-chip.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line bit rate. `T = CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division). Requires `T >= 4`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: single clock; reset is asynchronous and active-low.
- `rx` in 1: asynchronous serial input. The line idles high.
- `data_out` out 8: last good byte received. Holds its value until the next good byte.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Constant 0 when `UART_RX_PARITY_EN` is undefined.
- `busy` out 1: high in every state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- Frame format: start (0), 8 data bits LSB first, optional even-parity bit, stop (1).
- IDLE: the bit counter is cleared. On `rx_s == 0`, go to START.
- START: count `T/2 - 1` cycles, then sample `rx_s`.
  - If 0: go to DATA and clear the counter.
  - If 1: this is a glitch. Return to IDLE with no output pulses.
- DATA: at each count `T - 1`, shift `rx_s` into bit `idx` and increment `idx`. After `idx == 7`, go to PARITY if enabled, otherwise to STOP.
- PARITY: sample at count `T - 1`. Latch `mismatch = ^{data, rx_s}` (even parity).
- STOP: sample at count `T - 1`. Register the result on the next edge:
  - Stop bit 1 and no mismatch: load `data_out`, pulse `data_valid`, go to IDLE.
  - Stop bit 0: pulse `frame_err`, do not update `data_out`, go to RECOVER.
  - Mismatch: pulse `parity_err`, do not update `data_out`. Go to IDLE, or to RECOVER if the stop bit was also 0. When both errors occur, both pulses fire in the same cycle.
- RECOVER: wait for `rx_s == 1`, then go to IDLE. This prevents a line break being re-read as a string of 0x00 frames.
- A new start bit is accepted in the cycle after STOP completes, so back-to-back frames with no idle gap are received.
- Reset values:
  - state IDLE, counters 0, shift register 0;
  - `data_out = 8'h00`;
  - `data_valid`, `frame_err`, `parity_err`, `busy` all 0.
- Reset asserted mid-frame: all of the above take effect immediately. The partial byte is discarded with no pulses.

## Timing
- All outputs are registered.
- Synchronizer latency is 2 cycles.
- Sample points fall at `T/2 + k*T` cycles after `rx_s` falls, for k = 0 (start), 1..8 (data), 9 (parity, if enabled), and the final k (stop).
- `data_valid` / `frame_err` / `parity_err` rise `9.5*T + 2..4` clocks after the `rx` falling edge without parity, or `10.5*T + 2..4` clocks with parity. Each is high for exactly 1 cycle.
- `busy` rises 1 cycle after `rx_s` falls. It falls in the same cycle the result pulse is asserted, or on exit from RECOVER.
- Glitch rejection: a low pulse shorter than `T/2 - 1` cycles produces no pulses.
- Counter width is `$clog2(T)`. The counter wraps to 0 at each sample point.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in and frames are 11 bits;
  - an even-parity mismatch pulses `parity_err` and suppresses `data_valid`.
- `UART_RX_PARITY_EN` undefined:
  - no PARITY state and frames are 10 bits (8N1);
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD_RATE=1`, so `T=16`.
- Send 0xA5 as 8N1 -> exactly one `data_valid` pulse, `data_out = 0xA5`, `frame_err = 0`, pulse within the 154..156-clock window.
- Send 0x00 then 0xFF back-to-back with zero idle -> two `data_valid` pulses, `data_out` reads 0x00 then 0xFF, no errors.
- Drive `rx` low for 4 clocks, then high -> `busy` returns to 0 within 8 clocks, no pulses, `data_out` unchanged.
- After a good 0x11, send 0x3C with stop bit 0, hold `rx` low 40 clocks, then idle, then send 0x5A -> one `frame_err` pulse and `data_out` stays 0x11; no frames received during the low hold; then `data_valid` with 0x5A.
- Assert `rst` low during data bit 3 of 0x81 -> all outputs read their reset values within the same cycle; after release, a clean 0x81 frame gives `data_valid` and 0x81.
- With `UART_RX_PARITY_EN`:
  - 0x07 with parity bit 1 -> `data_valid`, `data_out = 0x07`.
  - 0x07 with parity bit 0 -> `parity_err` pulse only, no `data_valid`.
